prio_encoder_pipe: RTL and testbench
====================================

PRIO_ENCODER_PIPE -- requirements
Module: prio_encoder_pipe

Interface
REQ-001 SHALL have parameter N, default 8, meaning request vector width; legal values are powers of two from 2 to 64.
REQ-002 SHALL have parameter MODE, default 0, meaning 0 = strict one-hot, 1 = fixed priority (bit 0 highest), 2 = round-robin.
REQ-003 SHALL have derived localparam W = clog2(N), the index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  data is presented.
REQ-007 SHALL have port in_data  input  N  request/one-hot vector.
REQ-008 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL have port out_valid  output  1  out_idx/out_none/out_err are valid.
REQ-010 SHALL have port out_idx  output  W  encoded index.
REQ-011 SHALL have port out_none  output  1  accepted vector was all zeros.
REQ-012 SHALL have port out_err  output  1  accepted vector was multi-hot (MODE 0 only).
REQ-013 SHALL have port out_ready  input  1  downstream consumes the output.

Function
REQ-014 SHALL accept input on a cycle where in_valid && in_ready (input transfer).
REQ-015 SHALL drive in_ready = !out_valid || out_ready, combinationally, with no bubble under continuous flow.
REQ-016 SHALL present results in the cycle after the transfer (latency 1), holding out_* stable while out_valid && !out_ready.
REQ-017 SHALL clear out_valid after an output transfer (out_valid && out_ready) when no input transfer occurs in the same cycle.
REQ-018 SHALL load the new result and keep out_valid = 1 when input and output transfers coincide.
REQ-019 SHALL, in MODE 0 with exactly one bit k set, output out_idx = k, out_err = 0, out_none = 0.
REQ-020 SHALL, in MODE 0 with two or more bits set, output out_err = 1, out_idx = 0, out_none = 0.
REQ-021 SHALL, in MODE 1, output the index of the lowest set bit, with out_err = 0.
REQ-022 SHALL, in MODE 2, output the first set bit at or above pointer ptr, searching upward and wrapping from N-1 to 0, with out_err = 0.
REQ-023 SHALL, in MODE 2, update ptr to (granted index + 1) mod N on every input transfer with a non-zero vector; ptr wraps naturally in W bits.
REQ-024 SHALL, in all modes, output out_none = 1, out_idx = 0, out_err = 0 for an all-zero vector, leaving ptr unchanged.
REQ-025 SHALL NOT change ptr or out_* when in_valid = 1 but in_ready = 0.
REQ-026 SHALL never produce X on any output; don't-care encodings are forbidden.

Reset
REQ-027 SHALL, on rst_n low, immediately set out_valid = 0, out_idx = 0, out_none = 0, out_err = 0, ptr = 0, independent of clk.
REQ-028 SHALL drop any result held at reset without presenting it afterwards; in_ready = 1 while in reset.
REQ-029 SHALL accept input on the first rising clk edge after rst_n deasserts.

Structure
REQ-030 SHALL place the MODE encodings (MODE_ONEHOT = 0, MODE_FIXED = 1, MODE_RR = 2) in shared package prio_enc_pkg.
REQ-031 SHALL implement the lowest-set-bit search as one combinational sub-module, prio_enc_fixed (parameter N; outputs idx, none).
REQ-032 SHALL implement MODE 2 by masking bits below ptr, then applying prio_enc_fixed to the masked vector, falling back to the unmasked result when the masked vector is zero.
REQ-033 SHALL limit sequential state to ptr and the output register.

Verification (N=8)
REQ-034 SHALL cover: MODE 0, each of 8'h01..8'h80 with out_ready=1 -> out_idx 0..7 one cycle later, out_err=0, back-to-back at one result per cycle.
REQ-035 SHALL cover: MODE 0, 8'h81 then 8'h00 -> out_err=1 out_idx=0, then out_none=1 out_idx=0.
REQ-036 SHALL cover: MODE 1, 8'hA8 -> out_idx=3; 8'h80 -> out_idx=7.
REQ-037 SHALL cover: MODE 2, 8'h11 presented four times -> out_idx 0,4,0,4 (ptr 1,5,1,5); 8'h00 between them leaves the sequence unchanged.
REQ-038 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* held; release -> next vector appears on the following cycle with nothing lost or duplicated.
REQ-039 SHALL cover: rst_n asserted mid-clock while out_valid=1 and MODE 2 ptr=5 -> out_valid=0 and ptr=0 without a clk edge; next 8'hFF -> out_idx=0.

Source files
------------

// File: rtl/prio_enc_pkg.sv
// Shared encodings for the priority encoder family.
package prio_enc_pkg;

  localparam int MODE_ONEHOT = 0;
  localparam int MODE_FIXED  = 1;
  localparam int MODE_RR     = 2;

endpackage

// File: rtl/prio_enc_fixed.sv
// Combinational lowest-set-bit encoder; idx is 0 when no bit is set.
module prio_enc_fixed #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         none
);

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx  = W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/prio_encoder_pipe.sv
// Single-stage registered priority encoder: one-hot check, fixed priority
// or round-robin arbitration selected by MODE, with valid/ready handshakes.
module prio_encoder_pipe
  import prio_enc_pkg::*;
#(
  parameter int N    = 8,
  parameter int MODE = 0,
  localparam int W   = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_err,
  input  logic         out_ready
);

  logic [W-1:0] ptr;
  logic [N-1:0] mask;
  logic [N-1:0] masked;
  logic [W-1:0] all_idx;
  logic         all_none;
  logic [W-1:0] msk_idx;
  logic         msk_none;
  logic         multi_hot;
  logic [W-1:0] nxt_idx;
  logic         nxt_err;
  logic         in_xfer;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;

  // Round-robin only considers bits at or above the pointer on the first pass.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  assign masked    = in_data & mask;
  assign multi_hot = |(in_data & (in_data - N'(1)));

  prio_enc_fixed #(.N(N)) u_fix_all (
    .req  (in_data),
    .idx  (all_idx),
    .none (all_none)
  );

  prio_enc_fixed #(.N(N)) u_fix_masked (
    .req  (masked),
    .idx  (msk_idx),
    .none (msk_none)
  );

  always_comb begin
    nxt_idx = all_idx;
    nxt_err = 1'b0;
    if (MODE == MODE_ONEHOT) begin
      nxt_err = multi_hot;
      nxt_idx = multi_hot ? '0 : all_idx;
    end else if (MODE == MODE_RR) begin
      nxt_idx = msk_none ? all_idx : msk_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_none  <= 1'b0;
      out_err   <= 1'b0;
      ptr       <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_idx   <= nxt_idx;
        out_none  <= all_none;
        out_err   <= nxt_err;
        // Pointer moves past the grant and wraps within W bits.
        if (MODE == MODE_RR && !all_none) begin
          ptr <= nxt_idx + W'(1);
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_encoder_pipe.sv
// Scoreboard bench: three encoder instances (one per mode) driven in lockstep
// and checked against an independent behavioural model.
module tb_prio_encoder_pipe;

  typedef struct packed {
    logic [2:0] idx;
    logic       none;
    logic       err;
  } res_t;

  typedef struct packed {
    res_t rr;
    res_t fx;
    res_t oh;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic [2:0]      in_ready_m;
  logic [2:0]      out_valid_m;
  logic [2:0][2:0] out_idx_m;
  logic [2:0]      out_none_m;
  logic [2:0]      out_err_m;

  exp_t       sb[$];
  logic [2:0] mptr;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  prio_encoder_pipe #(.N(8), .MODE(0)) u_onehot (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m[0]), .out_valid(out_valid_m[0]), .out_idx(out_idx_m[0]),
    .out_none(out_none_m[0]), .out_err(out_err_m[0]), .out_ready(out_ready)
  );

  prio_encoder_pipe #(.N(8), .MODE(1)) u_fixed (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m[1]), .out_valid(out_valid_m[1]), .out_idx(out_idx_m[1]),
    .out_none(out_none_m[1]), .out_err(out_err_m[1]), .out_ready(out_ready)
  );

  prio_encoder_pipe #(.N(8), .MODE(2)) u_rr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m[2]), .out_valid(out_valid_m[2]), .out_idx(out_idx_m[2]),
    .out_none(out_none_m[2]), .out_err(out_err_m[2]), .out_ready(out_ready)
  );

  function automatic res_t model(int mode, logic [7:0] d, logic [2:0] p);
    res_t r;
    int   cnt;
    bit   found;
    r     = '0;
    cnt   = 0;
    found = 0;
    if (d == 8'h00) begin
      r.none = 1'b1;
      return r;
    end
    for (int i = 0; i < 8; i++) if (d[i]) cnt++;
    if (mode == 0 && cnt > 1) begin
      r.err = 1'b1;
      return r;
    end
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (mode == 2) ? ((int'(p) + k) % 8) : k;
      if (!found && d[j]) begin
        r.idx = 3'(j);
        found = 1;
      end
    end
    return r;
  endfunction

  function automatic res_t pick(exp_t e, int m);
    case (m)
      0:       return e.oh;
      1:       return e.fx;
      default: return e.rr;
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Compares every instance against the scoreboard, then models the edge to come.
  task automatic checkOutput();
    logic exp_valid;
    exp_t e;
    res_t r;
    exp_valid = (sb.size() != 0);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("in_ready[m%0d]", m), 8'(in_ready_m[m]), 8'(!exp_valid || out_ready));
      check($sformatf("out_valid[m%0d]", m), 8'(out_valid_m[m]), 8'(exp_valid));
      if (exp_valid) begin
        r = pick(sb[0], m);
        check($sformatf("out_idx[m%0d]", m), 8'(out_idx_m[m]), 8'(r.idx));
        check($sformatf("out_none[m%0d]", m), 8'(out_none_m[m]), 8'(r.none));
        check($sformatf("out_err[m%0d]", m), 8'(out_err_m[m]), 8'(r.err));
      end
    end
    if (exp_valid && out_ready) void'(sb.pop_front());
    if (in_valid && (!exp_valid || out_ready)) begin
      e.oh = model(0, in_data, mptr);
      e.fx = model(1, in_data, mptr);
      e.rr = model(2, in_data, mptr);
      sb.push_back(e);
      if (in_data != 8'h00) mptr = e.rr.idx + 3'd1;
    end
  endtask

  task automatic applyStimulus(logic v, logic [7:0] d, logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(string tag);
    for (int m = 0; m < 3; m++) begin
      check($sformatf("%s out_valid[m%0d]", tag, m), 8'(out_valid_m[m]), 8'h00);
      check($sformatf("%s out_idx[m%0d]", tag, m), 8'(out_idx_m[m]), 8'h00);
      check($sformatf("%s out_none[m%0d]", tag, m), 8'(out_none_m[m]), 8'h00);
      check($sformatf("%s out_err[m%0d]", tag, m), 8'(out_err_m[m]), 8'h00);
      check($sformatf("%s in_ready[m%0d]", tag, m), 8'(in_ready_m[m]), 8'h01);
    end
  endtask

  initial begin
    mptr      = '0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    // One-hot walk, back to back.
    for (int k = 0; k < 8; k++) applyStimulus(1'b1, 8'(1 << k), 1'b1);

    // Multi-hot then empty.
    applyStimulus(1'b1, 8'h81, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);

    // Fixed-priority picks.
    applyStimulus(1'b1, 8'hA8, 1'b1);
    applyStimulus(1'b1, 8'h80, 1'b1);

    // Round-robin alternation with empty vectors interleaved.
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h00, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b1);

    // Backpressure: the 0x40 vector must wait, then appear exactly once.
    applyStimulus(1'b1, 8'h06, 1'b1);
    repeat (3) applyStimulus(1'b1, 8'h40, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Bring the round-robin pointer to 5 and hold a result.
    applyStimulus(1'b1, 8'h11, 1'b1);
    applyStimulus(1'b1, 8'h11, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput();
    #2 rst_n = 1'b0;
    #1;
    checkResetState("async");
    sb.delete();
    mptr = '0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 8'hFF, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
